// File: rtl/params_pkg.sv
// Shared pipeline parameters, opcode set and access-size type.
// Mul/div helpers are used by ex_stage when EX_MULDIV_EN is defined.
package params_pkg;

    localparam int DATA_WIDTH     = 32;
    localparam int REGISTER_WIDTH = 5;
    localparam int MULDIV_CYCLES  = DATA_WIDTH;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } access_size_t;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
        ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_PASSB,
        ALU_MUL, ALU_MULH, ALU_MULHU,
        ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
    } alu_op_t;

    function automatic logic is_muldiv(alu_op_t op);
        return op inside {ALU_MUL, ALU_MULH, ALU_MULHU,
                          ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

    function automatic logic is_mul(alu_op_t op);
        return op inside {ALU_MUL, ALU_MULH, ALU_MULHU};
    endfunction

endpackage

// File: rtl/ex_muldiv_unit.sv
// Iterative mul/div: shift-add multiplier and restoring divider, one bit per cycle.
// Signed ops run on magnitudes; the sign is applied to the final result.
module ex_muldiv_unit
    import params_pkg::*;
#(
    parameter int W = MULDIV_CYCLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         abort,
    input  logic         start,
    input  alu_op_t      op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    alu_op_t        op_q;
    logic [CW-1:0]  cnt_q;
    logic           neg_q;
    logic           rneg_q;
    logic           div0_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   x_q;
    logic [W-1:0]   x_n;
    logic [2*W-1:0] y_q;
    logic [2*W-1:0] y_n;
    logic [2*W-1:0] acc_q;
    logic [2*W-1:0] acc_n;
    logic [W:0]     rem;
    logic [2*W-1:0] prod;
    logic [W-1:0]   quo;
    logic [W-1:0]   rmd;
    logic [W-1:0]   fin;
    logic           sgn;
    logic           sa;
    logic           sb;
    logic [W-1:0]   ma;
    logic [W-1:0]   mb;

    assign sgn  = op inside {ALU_MULH, ALU_DIV, ALU_REM};
    assign sa   = sgn & a[W-1];
    assign sb   = sgn & b[W-1];
    assign ma   = sa ? -a : a;
    assign mb   = sb ? -b : b;
    assign done = busy && (cnt_q == LAST);

    // x: multiplier / quotient, y: multiplicand / divisor, acc: product / remainder
    always_comb begin
        x_n   = x_q;
        y_n   = y_q;
        acc_n = acc_q;
        rem   = '0;
        if (is_mul(op_q)) begin
            if (x_q[0]) acc_n = acc_q + y_q;
            x_n = x_q >> 1;
            y_n = y_q << 1;
        end else begin
            rem = {acc_q[W-1:0], x_q[W-1]};
            x_n = x_q << 1;
            if (rem >= {1'b0, y_q[W-1:0]}) begin
                rem    = rem - {1'b0, y_q[W-1:0]};
                x_n[0] = 1'b1;
            end
            acc_n = {{(W-1){1'b0}}, rem};
        end
    end

    always_comb begin
        prod = neg_q ? -acc_n : acc_n;
        quo  = neg_q ? -x_n : x_n;
        rmd  = rneg_q ? -acc_n[W-1:0] : acc_n[W-1:0];
        unique case (op_q)
            ALU_MUL:             fin = prod[W-1:0];
            ALU_MULH, ALU_MULHU: fin = prod[2*W-1:W];
            ALU_DIV, ALU_DIVU:   fin = div0_q ? '1 : quo;
            default:             fin = div0_q ? a_q : rmd;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            busy   <= 1'b0;
            cnt_q  <= '0;
            result <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt_q  <= '0;
            op_q   <= op;
            neg_q  <= sa ^ sb;
            rneg_q <= sa;
            div0_q <= (b == '0);
            a_q    <= a;
            acc_q  <= '0;
            x_q    <= is_mul(op) ? mb : ma;
            y_q    <= {{W{1'b0}}, (is_mul(op) ? ma : mb)};
        end else if (busy) begin
            cnt_q <= cnt_q + 1'b1;
            x_q   <= x_n;
            y_q   <= y_n;
            acc_q <= acc_n;
            if (done) begin
                busy   <= 1'b0;
                result <= fin;
            end
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU / effective address, optional mul/div, EX/MEM register.
// Define EX_MULDIV_EN to build the iterative mul/div unit and its FSM.
module ex_stage
    import params_pkg::*;
#(
    parameter int DATA_WIDTH     = params_pkg::DATA_WIDTH,
    parameter int REGISTER_WIDTH = params_pkg::REGISTER_WIDTH
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      valid_i,
    input  alu_op_t                   alu_op_i,
    input  logic [DATA_WIDTH-1:0]     operand_a_i,
    input  logic [DATA_WIDTH-1:0]     operand_b_i,
    input  logic [DATA_WIDTH-1:0]     rs2_data_i,
    input  logic [REGISTER_WIDTH-1:0] wr_reg_i,
    input  logic                      is_load_i,
    input  logic                      is_store_i,
    input  logic                      reg_wr_en_i,
    input  access_size_t              access_size_i,
    input  logic                      mem_stall_i,
    input  logic                      flush_i,
    output logic                      stall_o,
    output logic                      mem_valid_o,
    output logic [DATA_WIDTH-1:0]     alu_result_o,
    output logic [DATA_WIDTH-1:0]     rs2_data_o,
    output logic [REGISTER_WIDTH-1:0] wr_reg_o,
    output logic                      is_load_o,
    output logic                      is_store_o,
    output logic                      reg_wr_en_o,
    output access_size_t              access_size_o
);

    logic [DATA_WIDTH-1:0] alu_res;
    logic [DATA_WIDTH-1:0] ex_result;
    logic [4:0]            shamt;
    logic                  load;

    assign shamt = operand_b_i[4:0];

    // Mul/div opcodes fall through to zero when no unit is built.
    always_comb begin
        alu_res = '0;
        unique case (alu_op_i)
            ALU_ADD:   alu_res = operand_a_i + operand_b_i;
            ALU_SUB:   alu_res = operand_a_i - operand_b_i;
            ALU_AND:   alu_res = operand_a_i & operand_b_i;
            ALU_OR:    alu_res = operand_a_i | operand_b_i;
            ALU_XOR:   alu_res = operand_a_i ^ operand_b_i;
            ALU_SLL:   alu_res = operand_a_i << shamt;
            ALU_SRL:   alu_res = operand_a_i >> shamt;
            ALU_SRA:   alu_res = $signed(operand_a_i) >>> shamt;
            ALU_SLT:   alu_res = {{(DATA_WIDTH-1){1'b0}},
                                  $signed(operand_a_i) < $signed(operand_b_i)};
            ALU_SLTU:  alu_res = {{(DATA_WIDTH-1){1'b0}},
                                  operand_a_i < operand_b_i};
            ALU_PASSB: alu_res = operand_b_i;
            default:   alu_res = '0;
        endcase
    end

`ifdef EX_MULDIV_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state;
    logic                  md_op;
    logic                  start;
    logic                  md_busy;
    logic                  md_done;
    logic [DATA_WIDTH-1:0] md_result;

    assign md_op = valid_i && is_muldiv(alu_op_i);
    // Never start while the memory stage is holding a live EX/MEM entry.
    assign start = (state == IDLE) && md_op && !flush_i
                   && !(mem_stall_i && mem_valid_o);

    ex_muldiv_unit #(
        .W(DATA_WIDTH)
    ) u_muldiv (
        .clk    (clk_i),
        .rst    (rst_i),
        .abort  (flush_i),
        .start  (start),
        .op     (alu_op_i),
        .a      (operand_a_i),
        .b      (operand_b_i),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_result)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE:    if (start) state <= BUSY;
                BUSY:    if (md_done) state <= DONE;
                DONE:    if (!mem_stall_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        unique case (state)
            IDLE:    stall_o = (md_op && !flush_i) || mem_stall_i;
            BUSY:    stall_o = md_busy;
            default: stall_o = mem_stall_i;
        endcase
    end

    assign load = (state == DONE)
                  || ((state == IDLE) && valid_i && !is_muldiv(alu_op_i));
    assign ex_result = (state == DONE) ? md_result : alu_res;
`else
    assign stall_o   = mem_stall_i;
    assign load      = valid_i;
    assign ex_result = alu_res;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_valid_o   <= 1'b0;
            alu_result_o  <= '0;
            rs2_data_o    <= '0;
            wr_reg_o      <= '0;
            is_load_o     <= 1'b0;
            is_store_o    <= 1'b0;
            reg_wr_en_o   <= 1'b0;
            access_size_o <= BYTE;
        end else if (flush_i) begin
            mem_valid_o <= 1'b0;
        end else if (!mem_stall_i) begin
            mem_valid_o <= load;
            if (load) begin
                alu_result_o  <= ex_result;
                rs2_data_o    <= rs2_data_i;
                wr_reg_o      <= wr_reg_i;
                is_load_o     <= is_load_i;
                is_store_o    <= is_store_i;
                reg_wr_en_o   <= reg_wr_en_i;
                access_size_o <= access_size_i;
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: directed cases plus randomised ops and stalls.
// Mul/div expectations follow whether EX_MULDIV_EN is defined for the build.
module tb_ex_stage;
    import params_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_i;
    logic         valid_i;
    alu_op_t      alu_op_i;
    logic [31:0]  operand_a_i;
    logic [31:0]  operand_b_i;
    logic [31:0]  rs2_data_i;
    logic [4:0]   wr_reg_i;
    logic         is_load_i;
    logic         is_store_i;
    logic         reg_wr_en_i;
    access_size_t access_size_i;
    logic         mem_stall_i;
    logic         flush_i;
    logic         stall_o;
    logic         mem_valid_o;
    logic [31:0]  alu_result_o;
    logic [31:0]  rs2_data_o;
    logic [4:0]   wr_reg_o;
    logic         is_load_o;
    logic         is_store_o;
    logic         reg_wr_en_o;
    access_size_t access_size_o;

    ex_stage dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .valid_i       (valid_i),
        .alu_op_i      (alu_op_i),
        .operand_a_i   (operand_a_i),
        .operand_b_i   (operand_b_i),
        .rs2_data_i    (rs2_data_i),
        .wr_reg_i      (wr_reg_i),
        .is_load_i     (is_load_i),
        .is_store_i    (is_store_i),
        .reg_wr_en_i   (reg_wr_en_i),
        .access_size_i (access_size_i),
        .mem_stall_i   (mem_stall_i),
        .flush_i       (flush_i),
        .stall_o       (stall_o),
        .mem_valid_o   (mem_valid_o),
        .alu_result_o  (alu_result_o),
        .rs2_data_o    (rs2_data_o),
        .wr_reg_o      (wr_reg_o),
        .is_load_o     (is_load_o),
        .is_store_o    (is_store_o),
        .reg_wr_en_o   (reg_wr_en_o),
        .access_size_o (access_size_o)
    );

    typedef struct {
        logic [31:0] res;
        logic [31:0] rs2;
        logic [9:0]  side;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    logic stall_rand = 1'b0;
    logic stall_force = 1'b0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the architectural rules.
    function automatic logic [31:0] model(alu_op_t op, logic [31:0] a,
                                          logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        logic [63:0] ua = {32'b0, a};
        logic [63:0] ub = {32'b0, b};
        logic [63:0] p;
        case (op)
            ALU_ADD:   return a + b;
            ALU_SUB:   return a - b;
            ALU_AND:   return a & b;
            ALU_OR:    return a | b;
            ALU_XOR:   return a ^ b;
            ALU_SLL:   return a << b[4:0];
            ALU_SRL:   return a >> b[4:0];
            ALU_SRA:   return 32'(sa >>> b[4:0]);
            ALU_SLT:   return (sa < sb) ? 32'd1 : 32'd0;
            ALU_SLTU:  return (a < b) ? 32'd1 : 32'd0;
            ALU_PASSB: return b;
            default:   ;
        endcase
`ifdef EX_MULDIV_EN
        case (op)
            ALU_MUL:   return 32'(sa * sb);
            ALU_MULH:  begin p = 64'(sa * sb); return p[63:32]; end
            ALU_MULHU: begin p = ua * ub; return p[63:32]; end
            ALU_DIV:   return (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            ALU_DIVU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            ALU_REM:   return (b == 0) ? a : 32'(sa % sb);
            ALU_REMU:  return (b == 0) ? a : a % b;
            default:   ;
        endcase
`endif
        return 32'd0;
    endfunction

    task automatic drive(input alu_op_t op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] rs2,
                         input logic [4:0] rd, input logic ld,
                         input logic st, input logic we,
                         input access_size_t sz);
        valid_i       = 1'b1;
        alu_op_i      = op;
        operand_a_i   = a;
        operand_b_i   = b;
        rs2_data_i    = rs2;
        wr_reg_i      = rd;
        is_load_i     = ld;
        is_store_i    = st;
        reg_wr_en_i   = we;
        access_size_i = sz;
    endtask

    task automatic push_current();
        exp_t e;
        e.res  = model(alu_op_i, operand_a_i, operand_b_i);
        e.rs2  = rs2_data_i;
        e.side = {wr_reg_i, is_load_i, is_store_i, reg_wr_en_i,
                  access_size_i};
        sb_q.push_back(e);
    endtask

    // Instruction is taken at the edge following a negedge with stall_o low.
    task automatic wait_accept();
        int n = 0;
        @(negedge clk);
        while (stall_o && n < 200) begin
            n++;
            @(negedge clk);
        end
        check("accept_timeout", {63'b0, stall_o}, 64'd0);
        if (!stall_o) push_current();
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, {63'b0, mem_valid_o}, 64'd0);
        check({tag, "_result"}, {32'b0, alu_result_o}, 64'd0);
        check({tag, "_rs2"}, {32'b0, rs2_data_o}, 64'd0);
        check({tag, "_side"}, {54'b0, wr_reg_o, is_load_o, is_store_o,
                               reg_wr_en_o, access_size_o}, 64'd0);
        check({tag, "_stall"}, {63'b0, stall_o}, 64'd0);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        mem_stall_i = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            mem_stall_i = stall_rand ? ($urandom_range(0, 3) == 0)
                                     : stall_force;
        end
    end

    always @(negedge clk) begin
        if (!rst_i && mem_valid_o && !mem_stall_i) begin
            if (sb_q.size() == 0) begin
                check("unexpected_output", {63'b0, mem_valid_o}, 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_result", {32'b0, alu_result_o}, {32'b0, mon_e.res});
                check("sb_rs2", {32'b0, rs2_data_o}, {32'b0, mon_e.rs2});
                check("sb_side", {54'b0, wr_reg_o, is_load_o, is_store_o,
                                  reg_wr_en_o, access_size_o},
                      {54'b0, mon_e.side});
            end
        end
    end

    initial begin
        rst_i = 1'b1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        drive(ALU_ADD, 0, 0, 0, 0, 0, 0, 0, BYTE);
        valid_i = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check_reset_outputs("reset");
        step();
        rst_i = 1'b0;

        // Signed overflow wraps
        drive(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 32'h11, 5'd1, 0, 0, 1, WORD);
        wait_accept();
        @(negedge clk);
        check("t1_valid", {63'b0, mem_valid_o}, 64'd1);
        check("t1_result", {32'b0, alu_result_o}, 64'h8000_0000);
        step();

        // Load held under a three-cycle memory stall
        drive(ALU_ADD, 32'h100, 32'h8, 32'hDEAD, 5'd3, 1, 0, 1, WORD);
        wait_accept();
        stall_force = 1'b1;
        drive(ALU_ADD, 32'd1, 32'd2, 32'h22, 5'd4, 0, 1, 0, HALF);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("t2_stall", {63'b0, stall_o}, 64'd1);
            check("t2_hold_valid", {63'b0, mem_valid_o}, 64'd1);
            check("t2_hold_result", {32'b0, alu_result_o}, 64'h108);
            check("t2_hold_load", {63'b0, is_load_o}, 64'd1);
            step();
        end
        stall_force = 1'b0;
        wait_accept();
        @(negedge clk);
        check("t2_next_valid", {63'b0, mem_valid_o}, 64'd1);
        check("t2_next_result", {32'b0, alu_result_o}, 64'd3);
        step();

`ifdef EX_MULDIV_EN
        // MUL latency: stall through cycle 32, result in cycle 34
        drive(ALU_MUL, 32'd7, 32'd6, 32'h33, 5'd5, 0, 0, 1, WORD);
        for (int c = 0; c <= 32; c++) begin
            @(negedge clk);
            check("t3_stall", {63'b0, stall_o}, 64'd1);
            step();
        end
        @(negedge clk);
        check("t3_done_stall", {63'b0, stall_o}, 64'd0);
        check("t3_bubble", {63'b0, mem_valid_o}, 64'd0);
        push_current();
        step();
        valid_i = 1'b0;
        @(negedge clk);
        check("t3_valid", {63'b0, mem_valid_o}, 64'd1);
        check("t3_result", {32'b0, alu_result_o}, 64'd42);
        step();
`else
        drive(ALU_MUL, 32'd7, 32'd6, 32'h33, 5'd5, 0, 0, 1, WORD);
        wait_accept();
        @(negedge clk);
        check("t3_valid", {63'b0, mem_valid_o}, 64'd1);
        check("t3_result", {32'b0, alu_result_o}, 64'd0);
        step();
`endif

        // Divide corner cases
        drive(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h1, 5'd6, 0, 0, 1, WORD);
        wait_accept();
        drive(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h2, 5'd7, 0, 0, 1, WORD);
        wait_accept();
        drive(ALU_DIVU, 32'd5, 32'd0, 32'h3, 5'd8, 0, 0, 1, WORD);
        wait_accept();
        drive(ALU_REMU, 32'd5, 32'd0, 32'h4, 5'd9, 0, 0, 1, WORD);
        wait_accept();
        repeat (2) step();

`ifdef EX_MULDIV_EN
        // Flush aborts an in-flight divide
        drive(ALU_DIV, 32'd100, 32'd7, 32'h5, 5'd10, 0, 0, 1, WORD);
        repeat (10) step();
        flush_i = 1'b1;
        valid_i = 1'b0;
        step();
        flush_i = 1'b0;
        sb_q.delete();
        @(negedge clk);
        check("t5_valid", {63'b0, mem_valid_o}, 64'd0);
        check("t5_stall", {63'b0, stall_o}, 64'd0);
        step();
        drive(ALU_ADD, 32'd10, 32'd20, 32'h6, 5'd11, 0, 0, 1, WORD);
        wait_accept();
        @(negedge clk);
        check("t5_add", {32'b0, alu_result_o}, 64'd30);
        step();
`endif

        // Flush beats a simultaneous memory stall
        drive(ALU_ADD, 32'd5, 32'd5, 32'h7, 5'd12, 0, 1, 0, BYTE);
        wait_accept();
        stall_force = 1'b1;
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        sb_q.delete();
        @(negedge clk);
        check("t5b_valid", {63'b0, mem_valid_o}, 64'd0);
        step();
        stall_force = 1'b0;
        step();

        // Reset mid-operation
`ifdef EX_MULDIV_EN
        drive(ALU_MUL, 32'd123, 32'd456, 32'h9, 5'd13, 1, 1, 1, HALF);
        repeat (5) step();
`else
        drive(ALU_ADD, 32'd9, 32'd9, 32'h9, 5'd13, 1, 1, 1, HALF);
        wait_accept();
        stall_force = 1'b1;
        step();
`endif
        rst_i = 1'b1;
        valid_i = 1'b0;
        stall_force = 1'b0;
        step();
        @(negedge clk);
        check_reset_outputs("t6_reset");
        sb_q.delete();
        step();
        rst_i = 1'b0;
        drive(ALU_SUB, 32'd3, 32'd5, 32'hA, 5'd14, 0, 0, 1, WORD);
        wait_accept();
        @(negedge clk);
        check("t6_valid", {63'b0, mem_valid_o}, 64'd1);
        check("t6_result", {32'b0, alu_result_o}, 64'hFFFF_FFFE);
        step();

        // Random ops, operands and memory stalls
        stall_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            drive(alu_op_t'(5'($urandom_range(0, 17))), rnd_operand(),
                  rnd_operand(), $urandom, 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  access_size_t'(2'($urandom_range(0, 2))));
            wait_accept();
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 2)) step();
        end
        stall_rand = 1'b0;
        for (int n = 0; n < 100 && sb_q.size() != 0; n++) step();
        check("drain", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
